// File: rtl/en_univ_shift_reg.sv
// Enable-gated universal shift register: hold / shift left / shift right / parallel load,
// optional rotate, saturating shift counter and a one-cycle done pulse at WIDTH shifts.
module en_univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter bit                 ROTATE    = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic in_l;
  logic in_r;
  logic is_shift;

  assign in_l     = ROTATE ? q[WIDTH-1] : sin;
  assign in_r     = ROTATE ? q[0]       : sin;
  assign is_shift = (mode == MODE_SHL) || (mode == MODE_SHR);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (mode_e'(mode))
        MODE_SHL:  q <= {q[WIDTH-2:0], in_l};
        MODE_SHR:  q <= {in_r, q[WIDTH-1:1]};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
      if (mode == MODE_LOAD) begin
        cnt <= '0;
      end else if (is_shift && (cnt < CNT_MAX)) begin
        // done marks only the transition into saturation, never later shifts
        cnt  <= cnt + 1'b1;
        done <= (cnt == CNT_LAST);
      end
    end
  end

  assign qbar   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_en_univ_shift_reg.sv
// Scoreboard bench: directed stimulus pushes hand-computed expected state per edge,
// a monitor pops and compares after each rising edge.
module tb_en_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q0, qb0, q1, qb1;
  logic       sl0, sr0, dn0, sl1, sr1, dn1;
  logic [3:0] c0, c1;

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  typedef struct {
    bit         rot;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  en_univ_shift_reg #(.WIDTH(8), .ROTATE(1'b0), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d),
    .q(q0), .qbar(qb0), .sout_l(sl0), .sout_r(sr0), .cnt(c0), .done(dn0)
  );

  en_univ_shift_reg #(.WIDTH(8), .ROTATE(1'b1), .RESET_VAL(8'h00)) dut_rot (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .d(d),
    .q(q1), .qbar(qb1), .sout_l(sl1), .sout_r(sr1), .cnt(c1), .done(dn1)
  );

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic s,
                      input logic [7:0] dd, input bit rot, input logic [7:0] eq,
                      input logic [3:0] ec, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; mode = m; sin = s; d = dd;
    x.rot = rot; x.q = eq; x.cnt = ec; x.done = ed; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: every rising edge presents a new register state
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (!x.rot) begin
          chk({x.name, " q"}, q0, x.q);
          chk({x.name, " qbar"}, qb0, ~x.q);
          chk({x.name, " cnt"}, {4'h0, c0}, {4'h0, x.cnt});
          chk({x.name, " done"}, {7'h0, dn0}, {7'h0, x.done});
          chk({x.name, " sout_l"}, {7'h0, sl0}, {7'h0, x.q[7]});
          chk({x.name, " sout_r"}, {7'h0, sr0}, {7'h0, x.q[0]});
        end else begin
          chk({x.name, " rq"}, q1, x.q);
          chk({x.name, " rqbar"}, qb1, ~x.q);
          chk({x.name, " rcnt"}, {4'h0, c1}, {4'h0, x.cnt});
          chk({x.name, " rdone"}, {7'h0, dn1}, {7'h0, x.done});
        end
      end
    end
  end

  localparam logic [7:0] T2_Q [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
  localparam logic [7:0] T4_Q [10] = '{8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h1F, 8'h1F,
                                       8'h0F, 8'h0F, 8'h07, 8'h07};
  localparam logic [3:0] T4_C [10] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
                                       4'd4, 4'd4, 4'd5, 4'd5};
  localparam logic [7:0] FILL_Q [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  localparam logic [7:0] ROT_Q [6] = '{8'h80, 8'h40, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    // 1: reset
    step(1, 0, 2'b01, 1, 8'hFF, 0, 8'hA5, 4'd0, 0, "t1_reset");
    step(1, 1, 2'b11, 0, 8'h00, 1, 8'h00, 4'd0, 0, "t1_reset_rot");

    // 2: load 81, eight left shifts, done pulse, then en=0 clears done
    step(0, 1, 2'b11, 0, 8'h81, 0, 8'h81, 4'd0, 0, "t2_load");
    for (int i = 0; i < 8; i++)
      step(0, 1, 2'b01, 0, 8'h00, 0, T2_Q[i], 4'(i + 1), (i == 7), "t2_shl");
    step(0, 0, 2'b01, 1, 8'h00, 0, 8'h00, 4'd8, 0, "t2_en_off");
    step(0, 1, 2'b00, 1, 8'h00, 0, 8'h00, 4'd8, 0, "t2_hold");

    // 3: rotate instance
    step(0, 1, 2'b11, 0, 8'h01, 1, 8'h01, 4'd0, 0, "t3_load");
    for (int i = 0; i < 6; i++)
      step(0, 1, (i < 3) ? 2'b10 : 2'b01, 0, 8'h00, 1, ROT_Q[i], 4'(i + 1), 0, "t3_rot");

    // 4: enable toggling during right shifts
    step(0, 1, 2'b11, 1, 8'hFF, 0, 8'hFF, 4'd0, 0, "t4_load");
    for (int i = 0; i < 10; i++)
      step(0, (i % 2 == 0), 2'b10, 0, 8'h00, 0, T4_Q[i], T4_C[i], 0, "t4_en");

    // 5: load pre-empts the completing shift, then reset mid-sequence
    step(0, 1, 2'b11, 0, 8'h00, 0, 8'h00, 4'd0, 0, "t5_load");
    for (int i = 0; i < 7; i++)
      step(0, 1, 2'b01, 1, 8'h00, 0, FILL_Q[i], 4'(i + 1), 0, "t5_shl");
    step(0, 1, 2'b11, 1, 8'h3C, 0, 8'h3C, 4'd0, 0, "t5_load_wins");
    step(0, 1, 2'b01, 1, 8'h00, 0, 8'h79, 4'd1, 0, "t5_shl2");
    step(0, 1, 2'b01, 1, 8'h00, 0, 8'hF3, 4'd2, 0, "t5_shl3");
    step(1, 1, 2'b01, 1, 8'h00, 0, 8'hA5, 4'd0, 0, "t5_reset");

    // 6: twelve left shifts of ones, saturation with a single done pulse
    step(0, 1, 2'b11, 1, 8'h00, 0, 8'h00, 4'd0, 0, "t6_load");
    for (int i = 0; i < 12; i++)
      step(0, 1, 2'b01, 1, 8'h00, 0, (i < 8) ? FILL_Q[i] : 8'hFF,
           (i < 8) ? 4'(i + 1) : 4'd8, (i == 7), "t6_sat");
    step(0, 1, 2'b10, 0, 8'h00, 0, 8'h7F, 4'd8, 0, "t6_sat_shr");

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && sb.size() == 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    if (budget >= 2000) begin
      errors++;
      $display("FAIL timeout: pending %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
